mips_mem_access_unit: RTL and testbench

//  Initiator side of the data-memory interface: takes load/store requests from the MEM stage and

---
 rtl/mips_mem_access_unit.sv | 104 ++++++++++
 tb/tb_mips_mem_access_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_access_unit.sv
// mips_mem_access_unit: load/store initiator for a byte-addressed data memory whose read lanes are big-endian
// and whose write lanes are little-endian; sub-word stores use read-modify-write.
module mips_mem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, DONE} state_t;
    state_t state, state_nxt;
    logic        r_write, r_signed;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, rd_word;
    logic [32:0] end_addr;
    logic        req_err, accept;
    logic [1:0]  k;
    logic [4:0]  sh_b, sh_h;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val, merged_b, merged_h, merged;
    assign end_addr = {1'b0, req_addr[31:2], 2'b00} + 33'd4;
    assign req_err  = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (end_addr > 33'(MEM_BYTES));
    assign accept   = req_valid && req_ready;
    // Byte k of a read sits at read_data[31-8k -: 8]; shifting by 8*(3-k) brings it to the bottom.
    assign k        = r_addr[1:0];
    assign sh_b     = {~k, 3'b000};
    assign sh_h     = {~k[1], 4'b0000};
    assign ld_byte  = 8'(read_data >> sh_b);
    assign ld_half  = 16'(read_data >> sh_h);
    assign load_val = r_size == 2'b00 ? {{24{r_signed & ld_byte[7]}}, ld_byte} :
                      r_size == 2'b01 ? {{16{r_signed & ld_half[15]}}, ld_half} : read_data;
    assign merged_b = (rd_word & ~(32'h0000_00FF << sh_b)) | ({24'b0, r_wdata[7:0]} << sh_b);
    assign merged_h = (rd_word & ~(32'h0000_FFFF << sh_h)) | ({16'b0, r_wdata[15:0]} << sh_h);
    assign merged   = r_size == 2'b10 ? r_wdata : r_size == 2'b01 ? merged_h : merged_b;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_err ? DONE : !req_write ? RD :
                                                req_size == 2'b10 ? WR : RMW_RD;
            RD:      state_nxt = DONE;
            RMW_RD:  state_nxt = WR;
            WR:      state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        req_ready     = state == IDLE;
        resp_valid    = state == DONE;
        sig_mem_read  = state == RD || state == RMW_RD;
        sig_mem_write = state == WR;
        mem_address   = (sig_mem_read || sig_mem_write) ? {r_addr[31:2], 2'b00} : 32'd0;
        // Memory stores write_data[7:0] at the lowest address, so the big-endian image is byte-reversed.
        write_data    = sig_mem_write ? {merged[7:0], merged[15:8], merged[23:16], merged[31:24]} : 32'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            r_write   <= 1'b0;
            r_signed  <= 1'b0;
            r_size    <= 2'b00;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            rd_word   <= 32'd0;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_write  <= req_write;
                r_signed <= req_signed;
                r_size   <= req_size;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (state == RMW_RD) rd_word <= read_data;
            if (accept && req_err) begin
                resp_data <= 32'd0;
                resp_err  <= 1'b1;
            end else if (state == RD) begin
                resp_data <= load_val;
                resp_err  <= 1'b0;
            end else if (state == WR) begin
                resp_data <= 32'd0;
                resp_err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mips_mem_access_unit.sv
// tb_mips_mem_access_unit: directed load/store vectors against a byte memory with the unit's lane order.
module tb_mips_mem_access_unit;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        resp_valid, resp_err, sig_mem_read, sig_mem_write;
    logic [31:0] resp_data, mem_address, write_data, read_data;
    logic [7:0]  mem [0:1023];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = 10'd0, ma;
    logic [31:0] poke_data = 32'd0;
    int vectors = 0, miscompares = 0;

    mips_mem_access_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_err(resp_err), .mem_address(mem_address),
        .write_data(write_data), .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
        .read_data(read_data)
    );

    always #5 clk = ~clk;

    assign ma = mem_address[9:0];
    assign read_data = {mem[ma], mem[ma + 10'd1], mem[ma + 10'd2], mem[ma + 10'd3]};

    always @(posedge clk) begin
        if (sig_mem_write) begin
            mem[ma]         <= write_data[7:0];
            mem[ma + 10'd1] <= write_data[15:8];
            mem[ma + 10'd2] <= write_data[23:16];
            mem[ma + 10'd3] <= write_data[31:24];
        end
        if (poke_en) begin
            mem[poke_addr]         <= poke_data[31:24];
            mem[poke_addr + 10'd1] <= poke_data[23:16];
            mem[poke_addr + 10'd2] <= poke_data[15:8];
            mem[poke_addr + 10'd3] <= poke_data[7:0];
        end
    end

    // Backdoor preload: stores d big-endian at a..a+3.
    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Issues one request and observes it up to its response (lat=0 means no response within budget).
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] data, output logic err,
                         output int lat, output int nrd, output int nwr, output logic [31:0] wimg,
                         output logic [31:0] sadr, output logic addr_moved, output logic rdy_done);
        logic have_adr;
        lat = 0; nrd = 0; nwr = 0; wimg = 32'd0; sadr = 32'd0; addr_moved = 1'b0;
        rdy_done = 1'b1; have_adr = 1'b0; data = 32'd0; err = 1'b0;
        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (sig_mem_read) nrd++;
            if (sig_mem_write) begin nwr++; wimg = write_data; end
            if (sig_mem_read || sig_mem_write) begin
                if (have_adr && mem_address != sadr) addr_moved = 1'b1;
                sadr = mem_address; have_adr = 1'b1;
            end
            if (resp_valid) begin
                lat = n; data = resp_data; err = resp_err; rdy_done = req_ready;
                break;
            end
        end
    endtask

    logic [31:0] d, wimg, sadr;
    logic        e, moved, rdy;
    int          lat, nrd, nwr;

    task automatic test_reset;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        vectors++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_data !== 32'd0) begin miscompares++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0 0 0", resp_valid, resp_err, resp_data); end
        vectors++; if (sig_mem_read !== 1'b0 || sig_mem_write !== 1'b0 || mem_address !== 32'd0 || write_data !== 32'd0) begin miscompares++; $display("FAIL reset_mem got r=%b w=%b a=%h wd=%h exp all 0", sig_mem_read, sig_mem_write, mem_address, write_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load;
        poke(10'h10, 32'h11223344);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL lw_latency got %0d exp 2", lat); end
        vectors++; if (d !== 32'h11223344 || e !== 1'b0) begin miscompares++; $display("FAIL lw_data got %h err %b exp 11223344 err 0", d, e); end
        vectors++; if (nrd != 1 || nwr != 0 || sadr !== 32'h10) begin miscompares++; $display("FAIL lw_strobes got rd=%0d wr=%0d a=%h exp 1 0 00000010", nrd, nwr, sadr); end
        vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL done_ready got %b exp 0", rdy); end
        repeat (2) @(negedge clk);
        vectors++; if (resp_data !== 32'h11223344 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL resp_hold got d=%h v=%b rdy=%b exp 11223344 0 1", resp_data, resp_valid, req_ready); end
    endtask

    task automatic test_extend;
        poke(10'h10, 32'h11223384);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'hFFFFFF84 || lat != 2) begin miscompares++; $display("FAIL lb got %h lat %0d exp ffffff84 2", d, lat); end
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'h00000084) begin miscompares++; $display("FAIL lbu got %h exp 00000084", d); end
        issue(1'b0, 2'b00, 1'b1, 32'h10, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'h00000011) begin miscompares++; $display("FAIL lb_pos got %h exp 00000011", d); end
        poke(10'h10, 32'h11228001);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh got %h exp ffff8001", d); end
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'h00008001) begin miscompares++; $display("FAIL lhu got %h exp 00008001", d); end
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'h00001122) begin miscompares++; $display("FAIL lh_low got %h exp 00001122", d); end
    endtask

    task automatic test_store_word;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (lat != 2 || nwr != 1 || nrd != 0) begin miscompares++; $display("FAIL sw_timing got lat=%0d wr=%0d rd=%0d exp 2 1 0", lat, nwr, nrd); end
        vectors++; if (wimg !== 32'hEFBEADDE || d !== 32'd0 || e !== 1'b0) begin miscompares++; $display("FAIL sw_image got wd=%h d=%h e=%b exp efbeadde 0 0", wimg, d, e); end
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_lw got %h exp deadbeef", d); end
    endtask

    task automatic test_store_sub;
        poke(10'h20, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (lat != 3 || nrd != 1 || nwr != 1) begin miscompares++; $display("FAIL sb_timing got lat=%0d rd=%0d wr=%0d exp 3 1 1", lat, nrd, nwr); end
        vectors++; if (wimg !== 32'h4433AA11 || sadr !== 32'h20 || moved !== 1'b0) begin miscompares++; $display("FAIL sb_image got wd=%h a=%h moved=%b exp 4433aa11 00000020 0", wimg, sadr, moved); end
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'h11AA3344) begin miscompares++; $display("FAIL sb_lw got %h exp 11aa3344", d); end
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (lat != 3 || wimg !== 32'hEFBEAA11 || moved !== 1'b0) begin miscompares++; $display("FAIL sh_image got lat=%0d wd=%h moved=%b exp 3 efbeaa11 0", lat, wimg, moved); end
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'h11AABEEF) begin miscompares++; $display("FAIL sh_lw got %h exp 11aabeef", d); end
        issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000077, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (wimg !== 32'hEFBEAA77) begin miscompares++; $display("FAIL sb0_image got %h exp efbeaa77", wimg); end
    endtask

    task automatic test_errors;
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        issue(1'b0, 2'b10, 1'b0, 32'h22, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (e !== 1'b1 || d !== 32'd0 || lat != 1 || nrd + nwr != 0) begin miscompares++; $display("FAIL err_lw_mis got e=%b d=%h lat=%0d strobes=%0d exp 1 0 1 0", e, d, lat, nrd + nwr); end
        issue(1'b1, 2'b01, 1'b0, 32'h01, 32'h5555, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (e !== 1'b1 || lat != 1 || nrd + nwr != 0) begin miscompares++; $display("FAIL err_sh_mis got e=%b lat=%0d strobes=%0d exp 1 1 0", e, lat, nrd + nwr); end
        issue(1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (e !== 1'b0 || lat != 2 || nrd != 1) begin miscompares++; $display("FAIL lw_top got e=%b lat=%0d rd=%0d exp 0 2 1", e, lat, nrd); end
        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (e !== 1'b1 || lat != 1 || nrd + nwr != 0) begin miscompares++; $display("FAIL err_range got e=%b lat=%0d strobes=%0d exp 1 1 0", e, lat, nrd + nwr); end
        issue(1'b1, 2'b00, 1'b0, 32'h403, 32'h1, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (e !== 1'b1 || nrd + nwr != 0) begin miscompares++; $display("FAIL err_sb_range got e=%b strobes=%0d exp 1 0", e, nrd + nwr); end
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (e !== 1'b1 || d !== 32'd0 || nrd + nwr != 0) begin miscompares++; $display("FAIL err_size got e=%b d=%h strobes=%0d exp 1 0 0", e, d, nrd + nwr); end
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (e !== 1'b0 || d !== 32'h00000022) begin miscompares++; $display("FAIL err_clear got e=%b d=%h exp 0 00000022", e, d); end
    endtask

    task automatic test_reset_mid;
        logic seen_wr, bad;
        seen_wr = 1'b0; bad = 1'b0;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h21; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (sig_mem_write) begin seen_wr = 1'b1; break; end
        end
        vectors++; if (seen_wr !== 1'b1) begin miscompares++; $display("FAIL rst_mid_reach_wr got %b exp 1", seen_wr); end
        rst_n = 1'b0;
        #1;
        vectors++; if (sig_mem_write !== 1'b0 || sig_mem_read !== 1'b0 || mem_address !== 32'd0 || write_data !== 32'd0) begin miscompares++; $display("FAIL rst_mid_strobes got r=%b w=%b a=%h wd=%h exp all 0", sig_mem_read, sig_mem_write, mem_address, write_data); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1 || sig_mem_write !== 1'b0) bad = 1'b1;
        end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL rst_mid_quiet got %b exp 0", bad); end
        vectors++; if (mem[33] !== 8'hAA) begin miscompares++; $display("FAIL rst_mid_mem got %h exp aa", mem[33]); end
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, d, e, lat, nrd, nwr, wimg, sadr, moved, rdy);
        vectors++; if (d !== 32'h77AABEEF || lat != 2) begin miscompares++; $display("FAIL rst_mid_recover got %h lat %0d exp 77aabeef 2", d, lat); end
    endtask

    initial begin
        test_reset;
        test_load;
        test_extend;
        test_store_word;
        test_store_sub;
        test_errors;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
